upsample_stream_ub: RTL and testbench

- Parametrised streaming nearest-neighbour upsampling buffer; successor to the fixed 2x, 64x64, single-channel, address-indexed up_sample buffers.
- Accepts a row-major input frame of IN_W x IN_H pixels, each CH lanes wide, on a valid/ready stream.
- Emits the (IN_W*SX) x (IN_H*SY) upsampled frame on a valid/ready stream.
- Sits between the input-stencil producer and the output-stencil consumer. Stores only two input rows (ping-pong) instead of a full frame.

---
 rtl/upsample_stream_ub.sv | 206 ++++++++++++++++++++
 tb/tb_upsample_stream_ub.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsample_stream_ub.sv
// Streaming nearest-neighbour upsampler: two ping-pong row banks, each row is
// replayed SY times with every pixel repeated SX times, emitted row-major.
module upsample_stream_ub #(
    parameter  int DATA_W = 16,
    parameter  int CH     = 1,
    parameter  int IN_W   = 64,
    parameter  int IN_H   = 64,
    parameter  int SX     = 2,
    parameter  int SY     = 2,
    localparam int PW     = CH * DATA_W,
    localparam int XW     = $clog2(IN_W * SX),
    localparam int YW     = (IN_H * SY > 1) ? $clog2(IN_H * SY) : 1
) (
    input  logic          clk,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_last
);
    localparam int CW  = $clog2(IN_W);
    localparam int RW  = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int SXW = (SX > 1) ? $clog2(SX) : 1;
    localparam int SYW = (SY > 1) ? $clog2(SY) : 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t         state;
    logic [PW-1:0]  bank [2][IN_W];
    logic [1:0]     full;
    logic           wb;
    logic           rb;
    logic [CW-1:0]  in_col;
    logic [RW-1:0]  in_row;
    logic [SXW-1:0] sx_cnt;
    logic [CW-1:0]  src_col;
    logic [SYW-1:0] rep;
    logic [YW-1:0]  y_base;

    logic           wr_en;
    logic           row_done;
    logic           advance;
    logic           bank_end;
    logic           pop;
    logic [1:0]     set_mask;
    logic [1:0]     clr_mask;
    logic [YW-1:0]  next_base;

    logic [SXW-1:0] nxt_sx;
    logic [CW-1:0]  nxt_col;
    logic [SYW-1:0] nxt_rep;
    logic [XW-1:0]  nxt_x;
    logic [YW-1:0]  nxt_y;
    logic           rd_sel;
    logic [CW-1:0]  rd_col;
    logic [PW-1:0]  rd_data;

    function automatic logic is_last(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x == XW'(IN_W * SX - 1)) && (y == YW'(IN_H * SY - 1));
    endfunction

    assign in_ready  = !full[wb];
    assign wr_en     = in_valid && in_ready;
    assign row_done  = wr_en && (in_col == CW'(IN_W - 1));
    assign advance   = (state == EMIT) && (!out_valid || out_ready);
    assign bank_end  = (sx_cnt == SXW'(SX - 1)) && (src_col == CW'(IN_W - 1))
                    && (rep == SYW'(SY - 1));
    assign pop       = advance && bank_end;
    assign next_base = (y_base == YW'(IN_H * SY - SY)) ? '0 : y_base + YW'(SY);

    // A freed bank and a completed row always hit different banks, so set and clear never collide.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        set_mask = '0;
        clr_mask = '0;
        if (row_done) set_mask[wb] = 1'b1;
        if (pop)      clr_mask[rb] = 1'b1;
    end

    // Position of the beat that follows the current one within the same bank.
    always_comb begin
        nxt_sx  = sx_cnt;
        nxt_col = src_col;
        nxt_rep = rep;
        nxt_x   = out_x;
        nxt_y   = out_y;
        if (sx_cnt != SXW'(SX - 1)) begin
            nxt_sx = sx_cnt + 1'b1;
            nxt_x  = out_x + 1'b1;
        end else begin
            nxt_sx = '0;
            if (src_col != CW'(IN_W - 1)) begin
                nxt_col = src_col + 1'b1;
                nxt_x   = out_x + 1'b1;
            end else begin
                nxt_col = '0;
                nxt_x   = '0;
                nxt_rep = rep + 1'b1;
                nxt_y   = out_y + 1'b1;
            end
        end
    end

    always_comb begin
        rd_sel = rb;
        rd_col = nxt_col;
        if (state == IDLE) begin
            rd_col = '0;
        end else if (bank_end) begin
            rd_sel = ~rb;
            rd_col = '0;
        end
    end

    assign rd_data = bank[rd_sel][rd_col];

    // NOTE: the row banks carry no reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) bank[wb][in_col] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state     <= IDLE;
            full      <= '0;
            wb        <= 1'b0;
            rb        <= 1'b0;
            in_col    <= '0;
            in_row    <= '0;
            sx_cnt    <= '0;
            src_col   <= '0;
            rep       <= '0;
            y_base    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else begin
            if (wr_en) begin
                if (row_done) begin
                    in_col <= '0;
                    wb     <= ~wb;
                    in_row <= (in_row == RW'(IN_H - 1)) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
            full <= (full | set_mask) & ~clr_mask;

            case (state)
                IDLE: begin
                    if (full[rb]) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_data  <= rd_data;
                        out_x     <= '0;
                        out_y     <= y_base;
                        out_last  <= is_last('0, y_base);
                        sx_cnt    <= '0;
                        src_col   <= '0;
                        rep       <= '0;
                    end
                end
                EMIT: begin
                    if (advance) begin
                        if (bank_end) begin
                            rb      <= ~rb;
                            y_base  <= next_base;
                            sx_cnt  <= '0;
                            src_col <= '0;
                            rep     <= '0;
                            out_x   <= '0;
                            out_y   <= next_base;
                            // Chain straight into the other bank when it is already waiting.
                            if (full[~rb]) begin
                                out_valid <= 1'b1;
                                out_data  <= rd_data;
                                out_last  <= is_last('0, next_base);
                            end else begin
                                state     <= IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            sx_cnt   <= nxt_sx;
                            src_col  <= nxt_col;
                            rep      <= nxt_rep;
                            out_x    <= nxt_x;
                            out_y    <= nxt_y;
                            out_data <= rd_data;
                            out_last <= is_last(nxt_x, nxt_y);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_upsample_stream_ub.sv
// Bench for upsample_stream_ub: stimulus pushes expected beats into per-instance
// queues, monitors pop and compare on every accepted output beat.
`timescale 1ns/1ps
module tb_upsample_stream_ub;

    typedef struct {
        int data;
        int x;
        int y;
        int last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic flush;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Instance a: IN_W=4, IN_H=2, SX=2, SY=2
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [15:0] a_in_data, a_out_data;
    logic [2:0]  a_out_x;
    logic [1:0]  a_out_y;
    // Instance b: IN_W=2, IN_H=1, SX=3, SY=1
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [15:0] b_in_data, b_out_data;
    logic [2:0]  b_out_x;
    logic [0:0]  b_out_y;
    // Instance c: IN_W=2, IN_H=1, SX=1, SY=1
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
    logic [15:0] c_in_data, c_out_data;
    logic [0:0]  c_out_x;
    logic [0:0]  c_out_y;

    upsample_stream_ub #(.DATA_W(16), .CH(1), .IN_W(4), .IN_H(2), .SX(2), .SY(2)) u_a (
        .clk(clk), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_x(a_out_x), .out_y(a_out_y), .out_last(a_out_last)
    );

    upsample_stream_ub #(.DATA_W(16), .CH(1), .IN_W(2), .IN_H(1), .SX(3), .SY(1)) u_b (
        .clk(clk), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_x(b_out_x), .out_y(b_out_y), .out_last(b_out_last)
    );

    upsample_stream_ub #(.DATA_W(16), .CH(1), .IN_W(2), .IN_H(1), .SX(1), .SY(1)) u_c (
        .clk(clk), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_x(c_out_x), .out_y(c_out_y), .out_last(c_out_last)
    );

    beat_t a_q[$];
    beat_t b_q[$];
    beat_t c_q[$];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic cmp_beat(input string tag, input beat_t e, input int d, input int x,
                            input int y, input int l);
        check({tag, " data"}, d, e.data);
        check({tag, " out_x"}, x, e.x);
        check({tag, " out_y"}, y, e.y);
        check({tag, " out_last"}, l, e.last);
    endtask

    // out_ready for instance a: 0 = held high, 1 = toggling, 2 = held low.
    int a_mode = 0;
    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (a_mode)
                1:       a_out_ready = ~a_out_ready;
                2:       a_out_ready = 1'b0;
                default: a_out_ready = 1'b1;
            endcase
        end
    end

    bit    a_stalled = 1'b0;
    beat_t a_held;
    always @(negedge clk) begin
        beat_t e;
        #1;
        if (a_stalled) begin
            check("a hold out_valid", int'(a_out_valid), 1);
            cmp_beat("a hold", a_held, int'(a_out_data), int'(a_out_x), int'(a_out_y),
                     int'(a_out_last));
        end
        a_stalled = a_out_valid && !a_out_ready && !flush;
        if (a_stalled) begin
            a_held.data = int'(a_out_data);
            a_held.x    = int'(a_out_x);
            a_held.y    = int'(a_out_y);
            a_held.last = int'(a_out_last);
        end
        if (a_out_valid && a_out_ready && !flush) begin
            if (a_q.size() == 0) check("a unexpected beat", int'(a_out_data), -1);
            else begin
                e = a_q.pop_front();
                cmp_beat("a beat", e, int'(a_out_data), int'(a_out_x), int'(a_out_y),
                         int'(a_out_last));
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        #1;
        if (b_out_valid && b_out_ready && !flush) begin
            if (b_q.size() == 0) check("b unexpected beat", int'(b_out_data), -1);
            else begin
                e = b_q.pop_front();
                cmp_beat("b beat", e, int'(b_out_data), int'(b_out_x), int'(b_out_y),
                         int'(b_out_last));
            end
        end
        if (c_out_valid && c_out_ready && !flush) begin
            if (c_q.size() == 0) check("c unexpected beat", int'(c_out_data), -1);
            else begin
                e = c_q.pop_front();
                cmp_beat("c beat", e, int'(c_out_data), int'(c_out_x), int'(c_out_y),
                         int'(c_out_last));
            end
        end
    end

    // Expected beats of one 4-pixel input row (pixels base..base+3) of instance a.
    task automatic push_row_a(input int base, input int row);
        beat_t e;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                for (int s = 0; s < 2; s++) begin
                    e.data = base + c;
                    e.x    = c * 2 + s;
                    e.y    = row * 2 + r;
                    e.last = (e.x == 7 && e.y == 3) ? 1 : 0;
                    a_q.push_back(e);
                end
    endtask

    task automatic push_b(input int d, input int x, input int l);
        beat_t e;
        e.data = d; e.x = x; e.y = 0; e.last = l;
        b_q.push_back(e);
    endtask

    task automatic push_c(input int d, input int x, input int l);
        beat_t e;
        e.data = d; e.x = x; e.y = 0; e.last = l;
        c_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, valid still high.
    task automatic send_a(input int d);
        int budget;
        budget = 0;
        a_in_valid = 1'b1;
        a_in_data  = 16'(d);
        while (!a_in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!a_in_ready) check("a in_ready wait expired", 0, 1);
        @(negedge clk);
    endtask

    task automatic send_b(input int d);
        int budget;
        budget = 0;
        b_in_valid = 1'b1;
        b_in_data  = 16'(d);
        while (!b_in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!b_in_ready) check("b in_ready wait expired", 0, 1);
        @(negedge clk);
    endtask

    task automatic send_c(input int d);
        int budget;
        budget = 0;
        c_in_valid = 1'b1;
        c_in_data  = 16'(d);
        while (!c_in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!c_in_ready) check("c in_ready wait expired", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_drain_a(input string tag);
        int budget;
        budget = 0;
        while (a_q.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check({tag, " pending beats"}, a_q.size(), 0);
    endtask

    initial begin
        int budget;
        flush      = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        flush = 1'b0;

        check("reset out_valid", int'(a_out_valid), 0);
        check("reset out_x", int'(a_out_x), 0);
        check("reset out_y", int'(a_out_y), 0);
        check("reset out_last", int'(a_out_last), 0);
        check("reset out_data", int'(a_out_data), 0);
        check("reset in_ready", int'(a_in_ready), 1);
        check("reset b out_valid", int'(b_out_valid), 0);
        check("reset c out_valid", int'(c_out_valid), 0);

        // Frame 1 with latency probe, then frame 2 back-to-back.
        push_row_a(10, 0);
        send_a(10); send_a(11); send_a(12); send_a(13);
        check("out_valid one edge after row end", int'(a_out_valid), 0);
        push_row_a(20, 1);
        send_a(20);
        check("first out_valid", int'(a_out_valid), 1);
        check("first out_data", int'(a_out_data), 10);
        check("first out_x", int'(a_out_x), 0);
        check("first out_y", int'(a_out_y), 0);
        send_a(21); send_a(22); send_a(23);
        push_row_a(30, 0);
        send_a(30); send_a(31); send_a(32); send_a(33);
        push_row_a(40, 1);
        send_a(40); send_a(41); send_a(42); send_a(43);
        a_in_valid = 1'b0;
        wait_drain_a("two frames");
        check("idle out_valid after frame", int'(a_out_valid), 0);
        check("out_x wrapped after frame", int'(a_out_x), 0);
        check("out_y wrapped after frame", int'(a_out_y), 0);

        // Toggling out_ready.
        a_mode = 1;
        push_row_a(50, 0);
        send_a(50); send_a(51); send_a(52); send_a(53);
        push_row_a(60, 1);
        send_a(60); send_a(61); send_a(62); send_a(63);
        a_in_valid = 1'b0;
        wait_drain_a("toggled ready");
        a_mode = 0;
        repeat (2) @(negedge clk);

        // Backpressure: both banks full stalls the input until the first bank drains.
        a_mode = 2;
        @(negedge clk);
        push_row_a(10, 0);
        send_a(10); send_a(11); send_a(12); send_a(13);
        push_row_a(20, 1);
        send_a(20); send_a(21); send_a(22); send_a(23);
        check("in_ready with both banks full", int'(a_in_ready), 0);
        push_row_a(30, 0);
        a_in_data = 16'd30;
        repeat (3) @(negedge clk);
        check("in_ready still stalled", int'(a_in_ready), 0);
        a_mode = 0;
        budget = 0;
        while (!(a_out_valid && a_out_ready && a_out_x == 3'd7 && a_out_y == 2'd1)
               && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("bank0 last beat seen", budget < 100 ? 1 : 0, 1);
        check("in_ready before bank freed", int'(a_in_ready), 0);
        @(negedge clk);
        check("in_ready one cycle after bank freed", int'(a_in_ready), 1);
        @(negedge clk);
        send_a(31); send_a(32); send_a(33);
        push_row_a(40, 1);
        send_a(40); send_a(41); send_a(42); send_a(43);
        a_in_valid = 1'b0;
        wait_drain_a("backpressure");

        // Flush during emission discards the pending outputs.
        a_mode = 2;
        @(negedge clk);
        send_a(70); send_a(71); send_a(72); send_a(73);
        a_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("emitting before flush", int'(a_out_valid), 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush out_valid", int'(a_out_valid), 0);
        check("flush out_x", int'(a_out_x), 0);
        check("flush in_ready", int'(a_in_ready), 1);
        a_mode = 0;

        // Flush mid-row, then a fresh row must come out from (0,0) without stale pixels.
        send_a(90); send_a(91);
        a_in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        push_row_a(40, 0);
        send_a(40); send_a(41); send_a(42); send_a(43);
        a_in_valid = 1'b0;
        wait_drain_a("after flush");

        // SX=3, SY=1: 5,6 -> 5,5,5,6,6,6, then a second frame restarting at x=0.
        push_b(5, 0, 0); push_b(5, 1, 0); push_b(5, 2, 0);
        push_b(6, 3, 0); push_b(6, 4, 0); push_b(6, 5, 1);
        push_b(7, 0, 0); push_b(7, 1, 0); push_b(7, 2, 0);
        push_b(8, 3, 0); push_b(8, 4, 0); push_b(8, 5, 1);
        send_b(5); send_b(6); send_b(7); send_b(8);
        b_in_valid = 1'b0;

        // SX=SY=1: output equals input.
        push_c(1, 0, 0); push_c(2, 1, 1);
        push_c(3, 0, 0); push_c(4, 1, 1);
        send_c(1); send_c(2); send_c(3); send_c(4);
        c_in_valid = 1'b0;

        budget = 0;
        while ((b_q.size() != 0 || c_q.size() != 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("b pending beats", b_q.size(), 0);
        check("c pending beats", c_q.size(), 0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active after %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule
